// File: rtl/reqack_pkg.sv
// Shared types and width helpers for the req/ack arbiter.
// Imported by the interface, the picker and the top.
package reqack_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        WAIT
    } state_e;

    // Index width for n requesters, never below one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Counter width able to hold the value m.
    function automatic int cnt_w(input int m);
        return (m > 0) ? $clog2(m + 1) : 1;
    endfunction

endpackage

// File: rtl/reqack_arbiter_if.sv
// Handshake bundle between requesters, resource and the arbiter.
// slave is the arbiter side, master is the agent side.
interface reqack_arbiter_if
    import reqack_pkg::*;
#(
    parameter int N_REQ = 4
);
    localparam int SW = idx_w(N_REQ);

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] ack;
    logic             start;
    logic [SW-1:0]    sel;
    logic             busy;
    logic             done;
    logic             intrpt;
    logic             timeout;
    logic             aborted;
    logic             spurious;

    modport slave (
        input  req, done, intrpt,
        output ack, start, sel, busy,
        output timeout, aborted, spurious
    );

    modport master (
        output req, done, intrpt,
        input  ack, start, sel, busy,
        input  timeout, aborted, spurious
    );

endinterface

// File: rtl/reqack_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit
// strictly after ptr, wrapping around.
module rr_pick
    import reqack_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int W     = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [W-1:0]     ptr,
    output logic             valid,
    output logic [W-1:0]     idx
);

    // Scan ptr+1 .. ptr+N_REQ modulo N_REQ, keep the first hit.
    always_comb begin
        logic [W-1:0] j;
        valid = 1'b0;
        idx   = '0;
        j     = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            j = W'((int'(ptr) + i) % N_REQ);
            if (!valid && req[j]) begin
                valid = 1'b1;
                idx   = j;
            end
        end
    end

endmodule

// File: rtl/reqack_arbiter.sv
// Round-robin arbiter/sequencer for one shared req/ack/done
// resource, with completion watchdog and interrupt abort.
module reqack_arbiter
    import reqack_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int MAX_CYC = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    reqack_arbiter_if.slave   bus
);

    localparam int SW = idx_w(N_REQ);
    localparam int CW = cnt_w(MAX_CYC);
    localparam logic [CW-1:0] CMAX = CW'(MAX_CYC);
    localparam logic [SW-1:0] PRST = SW'(N_REQ - 1);

    state_e           st, nxt;
    logic [SW-1:0]    ptr_q, ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             pick_v;
    logic [SW-1:0]    pick_i;

    logic [N_REQ-1:0] ack_q, ack_d;
    logic             start_q, start_d;
    logic [SW-1:0]    sel_q, sel_d;
    logic             busy_q, busy_d;
    logic             to_q, to_d;
    logic             ab_q, ab_d;
    logic             sp_q, sp_d;
    logic             grant;

    rr_pick #(.N_REQ(N_REQ), .W(SW)) u_pick (
        .req   (bus.req),
        .ptr   (ptr_q),
        .valid (pick_v),
        .idx   (pick_i)
    );

    // State, pointer and watchdog counter registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            st    <= IDLE;
            ptr_q <= PRST;
            cnt_q <= '0;
        end else begin
            st    <= nxt;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    // Next state plus the next value of every registered output.
    always_comb begin
        nxt     = st;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        grant   = 1'b0;
        ack_d   = '0;
        start_d = 1'b0;
        sel_d   = sel_q;
        to_d    = 1'b0;
        ab_d    = 1'b0;
        sp_d    = 1'b0;
        unique case (st)
            IDLE: begin
                sp_d = bus.done;
                if (pick_v) begin
                    grant = 1'b1;
                    nxt   = GRANT;
                end
            end
            GRANT: begin
                sp_d  = bus.done;
                ptr_d = sel_q;
                cnt_d = CW'(1);
                if (bus.intrpt) begin
                    ab_d = 1'b1;
                    nxt  = IDLE;
                end else begin
                    nxt  = WAIT;
                end
            end
            WAIT: begin
                if (bus.intrpt) begin
                    ab_d = 1'b1;
                    nxt  = IDLE;
                end else if (bus.done) begin
                    if (pick_v) begin
                        grant = 1'b1;
                        nxt   = GRANT;
                    end else begin
                        nxt   = IDLE;
                    end
                end else if (cnt_q == CMAX) begin
                    to_d = 1'b1;
                    nxt  = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: nxt = IDLE;
        endcase
        if (grant) begin
            sel_d         = pick_i;
            ack_d[pick_i] = 1'b1;
            start_d       = 1'b1;
        end
        busy_d = (nxt != IDLE);
    end

    // Output registers; reset clears every pulse.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ack_q   <= '0;
            start_q <= 1'b0;
            sel_q   <= '0;
            busy_q  <= 1'b0;
            to_q    <= 1'b0;
            ab_q    <= 1'b0;
            sp_q    <= 1'b0;
        end else begin
            ack_q   <= ack_d;
            start_q <= start_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            to_q    <= to_d;
            ab_q    <= ab_d;
            sp_q    <= sp_d;
        end
    end

    assign bus.ack      = ack_q;
    assign bus.start    = start_q;
    assign bus.sel      = sel_q;
    assign bus.busy     = busy_q;
    assign bus.timeout  = to_q;
    assign bus.aborted  = ab_q;
    assign bus.spurious = sp_q;

endmodule

// File: tb/tb_reqack_arbiter.sv
// Directed bench for reqack_arbiter (N_REQ=4, MAX_CYC=5).
// Hand-computed expectations, immediate-assertion checks.
module tb_reqack_arbiter;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    reqack_arbiter_if #(.N_REQ(4)) bus ();

    reqack_arbiter #(.N_REQ(4), .MAX_CYC(5)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    // Check the full output vector except sel.
    task automatic chk_all(input string tag,
                           input logic [3:0] e_ack,
                           input logic e_start,
                           input logic e_busy,
                           input logic e_to,
                           input logic e_ab,
                           input logic e_sp);
        chk({tag, ".ack"},      32'(bus.ack),      32'(e_ack));
        chk({tag, ".start"},    32'(bus.start),    32'(e_start));
        chk({tag, ".busy"},     32'(bus.busy),     32'(e_busy));
        chk({tag, ".timeout"},  32'(bus.timeout),  32'(e_to));
        chk({tag, ".aborted"},  32'(bus.aborted),  32'(e_ab));
        chk({tag, ".spurious"}, 32'(bus.spurious), 32'(e_sp));
    endtask

    initial begin
        logic [3:0] exp_ack;
        checks     = 0;
        errors     = 0;
        reset_n    = 1'b0;
        bus.req    = '0;
        bus.done   = 1'b0;
        bus.intrpt = 1'b0;
        tick();
        tick();
        chk_all("reset", 4'b0000, 0, 0, 0, 0, 0);
        chk("reset.sel", 32'(bus.sel), 0);

        // Intrpt in IDLE is ignored.
        reset_n    = 1'b1;
        bus.intrpt = 1'b1;
        tick();
        chk_all("idle_intrpt", 4'b0000, 0, 0, 0, 0, 0);
        bus.intrpt = 1'b0;

        // Fairness: all requesting, done one cycle after start.
        bus.req = 4'b1111;
        tick();
        chk_all("fair0", 4'b0001, 1, 1, 0, 0, 0);
        chk("fair0.sel", 32'(bus.sel), 0);
        for (int k = 1; k <= 4; k++) begin
            bus.done = 1'b0;
            if (k == 4) bus.req = 4'b0000;
            tick();
            chk_all("fair_wait", 4'b0000, 0, 1, 0, 0, 0);
            if (k == 4) bus.req = 4'b1111;
            bus.done = 1'b1;
            tick();
            exp_ack = 4'b0001 << (k % 4);
            chk_all("fair_grant", exp_ack, 1, 1, 0, 0, 0);
            chk("fair.sel", 32'(bus.sel), 32'(k % 4));
        end
        bus.done = 1'b0;
        bus.req  = 4'b0000;
        tick();
        bus.done = 1'b1;
        tick();
        chk_all("fair_end", 4'b0000, 0, 0, 0, 0, 0);
        bus.done = 1'b0;

        // Single request, done three cycles after start.
        bus.req = 4'b0100;
        tick();
        chk_all("single", 4'b0100, 1, 1, 0, 0, 0);
        chk("single.sel", 32'(bus.sel), 2);
        bus.req = 4'b0000;
        tick();
        chk_all("single_s1", 4'b0000, 0, 1, 0, 0, 0);
        tick();
        tick();
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        chk_all("single_end", 4'b0000, 0, 0, 0, 0, 0);

        // Done exactly at s+MAX_CYC is a success.
        bus.req = 4'b0001;
        tick();
        chk("edge.sel", 32'(bus.sel), 0);
        bus.req = 4'b0000;
        for (int k = 1; k <= 4; k++) tick();
        chk_all("edge_s4", 4'b0000, 0, 1, 0, 0, 0);
        tick();
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        chk_all("edge_ok", 4'b0000, 0, 0, 0, 0, 0);

        // No done: timeout at s+MAX_CYC+1.
        bus.req = 4'b0010;
        tick();
        chk("to.sel", 32'(bus.sel), 1);
        bus.req = 4'b0000;
        for (int k = 1; k <= 5; k++) tick();
        chk_all("to_s5", 4'b0000, 0, 1, 0, 0, 0);
        tick();
        chk_all("to_s6", 4'b0000, 0, 0, 1, 0, 0);
        tick();
        chk_all("to_s7", 4'b0000, 0, 0, 0, 0, 0);

        // Intrpt beats done; pointer has moved to 2.
        bus.req = 4'b0100;
        tick();
        chk("irq.sel", 32'(bus.sel), 2);
        bus.req = 4'b1100;
        tick();
        bus.done   = 1'b1;
        bus.intrpt = 1'b1;
        tick();
        bus.done   = 1'b0;
        bus.intrpt = 1'b0;
        chk_all("irq_abort", 4'b0000, 0, 0, 0, 1, 0);
        tick();
        chk_all("irq_next", 4'b1000, 1, 1, 0, 0, 0);
        bus.req = 4'b0000;
        tick();
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        chk_all("irq_end", 4'b0000, 0, 0, 0, 0, 0);

        // Done in IDLE: spurious only.
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        chk_all("spur_idle", 4'b0000, 0, 0, 0, 0, 1);
        tick();
        chk_all("spur_clr", 4'b0000, 0, 0, 0, 0, 0);

        // Intrpt plus done in GRANT: aborted with spurious.
        bus.req = 4'b0001;
        tick();
        chk_all("gabort_g", 4'b0001, 1, 1, 0, 0, 0);
        bus.req    = 4'b0000;
        bus.intrpt = 1'b1;
        bus.done   = 1'b1;
        tick();
        bus.intrpt = 1'b0;
        bus.done   = 1'b0;
        chk_all("gabort", 4'b0000, 0, 0, 0, 1, 1);

        // Reset in WAIT restores pointer to N_REQ-1.
        bus.req = 4'b0010;
        tick();
        bus.req = 4'b0000;
        tick();
        tick();
        reset_n = 1'b0;
        tick();
        chk_all("rst_wait", 4'b0000, 0, 0, 0, 0, 0);
        chk("rst_wait.sel", 32'(bus.sel), 0);
        reset_n = 1'b1;
        bus.req = 4'b1111;
        tick();
        chk_all("rst_grant", 4'b0001, 1, 1, 0, 0, 0);
        chk("rst_grant.sel", 32'(bus.sel), 0);
        bus.req = 4'b0000;
        tick();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
